// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, queue depth and write-queue entry type for reg_write_bank
package cpu_pkg;

    localparam int DATA_W  = 16;
    localparam int NUM_REGS = 16;
    localparam int SEL_W   = 4;
    localparam int Q_DEPTH = 2;

    typedef struct packed {
        logic [SEL_W-1:0]  select;
        logic [DATA_W-1:0] data;
    } wq_entry_t;

endpackage

// File: rtl/reg_write_bank_if.sv
// rtl/reg_write_bank_if.sv - write request handshake and drain stall for reg_write_bank
interface reg_write_bank_if #(
    parameter int DATA_W = cpu_pkg::DATA_W
);

    logic                      wr_valid;
    logic                      wr_ready;
    logic [cpu_pkg::SEL_W-1:0] wr_select;
    logic [DATA_W-1:0]         wr_data;
    logic                      hold;

    modport master (
        output wr_valid,
        output wr_select,
        output wr_data,
        output hold,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_select,
        input  wr_data,
        input  hold,
        output wr_ready
    );

endinterface

// File: rtl/write_queue2.sv
// rtl/write_queue2.sv - two-entry in-order queue, push and pop only, slot0 is always the head
module write_queue2
    import cpu_pkg::*;
#(
    parameter type entry_t = cpu_pkg::wq_entry_t
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   push_valid,
    input  entry_t push_entry,
    output logic   push_ready,
    input  logic   pop_req,
    output logic   pop_fire,
    output entry_t slot0,
    output entry_t slot1,
    output logic [1:0] slot_valid
);

    logic [1:0] count;
    logic [1:0] count_next;
    logic       push_fire;

    assign push_fire  = push_valid && push_ready;
    assign pop_fire   = pop_req && (count != 2'd0);
    assign slot_valid = {count == 2'd2, count != 2'd0};

    always_comb begin
        count_next = count;
        if (push_fire && !pop_fire) begin
            count_next = count + 2'd1;
        end else if (pop_fire && !push_fire) begin
            count_next = count - 2'd1;
        end
    end

    // push_ready is registered from the next occupancy so it never depends on push_valid
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= 2'd0;
            push_ready <= 1'b1;
            slot0      <= '0;
            slot1      <= '0;
        end else begin
            case ({push_fire, pop_fire})
                2'b10: begin
                    if (count == 2'd0) begin
                        slot0 <= push_entry;
                    end else begin
                        slot1 <= push_entry;
                    end
                end
                2'b01: begin
                    slot0 <= slot1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        slot0 <= push_entry;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_entry;
                    end
                end
                default: begin
                end
            endcase
            count      <= count_next;
            push_ready <= (count_next < 2'(Q_DEPTH));
        end
    end

endmodule

// File: rtl/reg_write_bank.sv
// rtl/reg_write_bank.sv - 16-entry register bank fed by a two-deep write queue
// Optional: REG_WRITE_BANK_R0_ZERO_EN makes r0 a hardwired zero register.
module reg_write_bank
    import cpu_pkg::*;
#(
    parameter int DATA_W   = cpu_pkg::DATA_W,
    parameter int NUM_REGS = cpu_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              reset_n,
    reg_write_bank_if.slave   wr,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] r8,
    output logic [DATA_W-1:0] r9,
    output logic [DATA_W-1:0] r10,
    output logic [DATA_W-1:0] r11,
    output logic [DATA_W-1:0] r12,
    output logic [DATA_W-1:0] r13,
    output logic [DATA_W-1:0] r14,
    output logic [DATA_W-1:0] r15,
    output logic [15:0]       pending_mask,
    output logic              busy
);

    typedef struct packed {
        logic [SEL_W-1:0]  select;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            push_entry;
    entry_t            slot0;
    entry_t            slot1;
    logic [1:0]        slot_valid;
    logic              drain;
    logic              write_en;
    logic [DATA_W-1:0] regs  [16];
    logic [DATA_W-1:0] rview [16];

    assign push_entry = '{select: wr.wr_select, data: wr.wr_data};

    write_queue2 #(
        .entry_t (entry_t)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_valid (wr.wr_valid),
        .push_entry (push_entry),
        .push_ready (wr.wr_ready),
        .pop_req    (!wr.hold),
        .pop_fire   (drain),
        .slot0      (slot0),
        .slot1      (slot1),
        .slot_valid (slot_valid)
    );

    // Drained writes to index 0 still leave the queue; they are only dropped here.
`ifdef REG_WRITE_BANK_R0_ZERO_EN
    assign write_en = drain && (int'(slot0.select) < NUM_REGS) && (slot0.select != '0);
`else
    assign write_en = drain && (int'(slot0.select) < NUM_REGS);
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[slot0.select] <= slot0.data;
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_view
`ifdef REG_WRITE_BANK_R0_ZERO_EN
        if (g == 0 || g >= NUM_REGS) begin : g_zero
`else
        if (g >= NUM_REGS) begin : g_zero
`endif
            assign rview[g] = '0;
        end else begin : g_reg
            assign rview[g] = regs[g];
        end
    end

    assign r0  = rview[0];
    assign r1  = rview[1];
    assign r2  = rview[2];
    assign r3  = rview[3];
    assign r4  = rview[4];
    assign r5  = rview[5];
    assign r6  = rview[6];
    assign r7  = rview[7];
    assign r8  = rview[8];
    assign r9  = rview[9];
    assign r10 = rview[10];
    assign r11 = rview[11];
    assign r12 = rview[12];
    assign r13 = rview[13];
    assign r14 = rview[14];
    assign r15 = rview[15];

    always_comb begin
        pending_mask = '0;
        if (slot_valid[0]) begin
            pending_mask[slot0.select] = 1'b1;
        end
        if (slot_valid[1]) begin
            pending_mask[slot1.select] = 1'b1;
        end
`ifdef REG_WRITE_BANK_R0_ZERO_EN
        pending_mask[0] = 1'b0;
`endif
    end

    assign busy = slot_valid[0];

endmodule

// File: tb/tb_reg_write_bank.sv
// tb/tb_reg_write_bank.sv - directed self-checking bench for reg_write_bank
module tb_reg_write_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] r [16];
    logic [15:0] pending_mask;
    logic        busy;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    reg_write_bank_if #(.DATA_W(16)) wif ();

    reg_write_bank #(
        .DATA_W   (16),
        .NUM_REGS (16)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr           (wif.slave),
        .r0           (r[0]),
        .r1           (r[1]),
        .r2           (r[2]),
        .r3           (r[3]),
        .r4           (r[4]),
        .r5           (r[5]),
        .r6           (r[6]),
        .r7           (r[7]),
        .r8           (r[8]),
        .r9           (r[9]),
        .r10          (r[10]),
        .r11          (r[11]),
        .r12          (r[12]),
        .r13          (r[13]),
        .r14          (r[14]),
        .r15          (r[15]),
        .pending_mask (pending_mask),
        .busy         (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] sel, input logic [15:0] d);
        wif.wr_valid  = v;
        wif.wr_select = sel;
        wif.wr_data   = d;
    endtask

    initial begin
        reset_n      = 1'b0;
        wif.hold     = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        tick();
        tick();
        reset_n = 1'b1;
        check("rst_ready", wif.wr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_mask", pending_mask, 16'h0000);
        check("rst_r5", r[5], 16'h0000);

        // single write, one-cycle latency
        drive(1'b1, 4'd5, 16'hBEEF);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        check("single_r5_not_yet", r[5], 16'h0000);
        check("single_mask", pending_mask, 16'h0020);
        check("single_busy", busy, 1);
        tick();
        check("single_r5", r[5], 16'hBEEF);
        check("single_mask_clr", pending_mask, 16'h0000);
        check("single_busy_clr", busy, 0);

        // queue full under hold
        wif.hold = 1'b1;
        drive(1'b1, 4'd3, 16'h0011);
        tick();
        check("full_ready_after1", wif.wr_ready, 1);
        drive(1'b1, 4'd4, 16'h0022);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        check("full_ready", wif.wr_ready, 0);
        check("full_busy", busy, 1);
        check("full_mask", pending_mask, 16'h0018);
        tick();
        check("full_frozen_r3", r[3], 16'h0000);
        wif.hold = 1'b0;
        tick();
        check("full_r3", r[3], 16'h0011);
        check("full_r4_not_yet", r[4], 16'h0000);
        check("full_mask_after1", pending_mask, 16'h0010);
        check("full_ready_after_drain", wif.wr_ready, 1);
        tick();
        check("full_r4", r[4], 16'h0022);
        check("full_busy_clr", busy, 0);

        // simultaneous push and drain at occupancy 1
        wif.hold = 1'b1;
        drive(1'b1, 4'd6, 16'h0606);
        tick();
        wif.hold = 1'b0;
        drive(1'b1, 4'd7, 16'h0707);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        check("sim_r6", r[6], 16'h0606);
        check("sim_busy", busy, 1);
        check("sim_mask", pending_mask, 16'h0080);
        check("sim_r7_not_yet", r[7], 16'h0000);
        tick();
        check("sim_r7", r[7], 16'h0707);
        check("sim_busy_clr", busy, 0);

        // same target back to back
        drive(1'b1, 4'd9, 16'h1111);
        tick();
        drive(1'b1, 4'd9, 16'h2222);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        check("same_r9_first", r[9], 16'h1111);
        check("same_mask_held", pending_mask, 16'h0200);
        tick();
        check("same_r9_final", r[9], 16'h2222);
        check("same_mask_clr", pending_mask, 16'h0000);

        // highest index
        drive(1'b1, 4'd15, 16'h1234);
        tick();
        drive(1'b0, 4'd0, 16'h0);
        check("top_mask", pending_mask, 16'h8000);
        tick();
        check("top_r15", r[15], 16'h1234);

        // reset with a full queue, hold and a write presented
        wif.hold = 1'b1;
        drive(1'b1, 4'd1, 16'hAAAA);
        tick();
        drive(1'b1, 4'd2, 16'hBBBB);
        tick();
        check("rm_ready_full", wif.wr_ready, 0);
        drive(1'b1, 4'd8, 16'hCCCC);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        wif.hold = 1'b0;
        drive(1'b0, 4'd0, 16'h0);
        check("rm_busy", busy, 0);
        check("rm_ready", wif.wr_ready, 1);
        check("rm_mask", pending_mask, 16'h0000);
        check("rm_r5", r[5], 16'h0000);
        check("rm_r9", r[9], 16'h0000);
        check("rm_r15", r[15], 16'h0000);
        tick();
        tick();
        check("rm_r1", r[1], 16'h0000);
        check("rm_r2", r[2], 16'h0000);
        check("rm_r8", r[8], 16'h0000);

        // index 0 behaviour depends on build option
        drive(1'b1, 4'd0, 16'hFFFF);
        tick();
        drive(1'b0, 4'd0, 16'h0);
`ifdef REG_WRITE_BANK_R0_ZERO_EN
        check("r0_mask", pending_mask, 16'h0000);
        check("r0_busy", busy, 1);
        tick();
        check("r0_value", r[0], 16'h0000);
`else
        check("r0_mask", pending_mask, 16'h0001);
        check("r0_busy", busy, 1);
        tick();
        check("r0_value", r[0], 16'hFFFF);
`endif
        check("r0_busy_clr", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/reg_write_bank.md
REG_WRITE_BANK -- requirements
Module: reg_write_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; select width is fixed at 4 bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port wr_valid  input  1  a write request is presented.
REQ-006 SHALL have port wr_ready  output  1  the block can accept a write this cycle.
REQ-007 SHALL have port wr_select  input  4  destination register index.
REQ-008 SHALL have port wr_data  input  DATA_W  write data.
REQ-009 SHALL have port hold  input  1  stalls draining of queued writes.
REQ-010 SHALL have ports r0..r15  output  DATA_W each  current register contents, which feed the read-side 16:1 select.
REQ-011 SHALL have port pending_mask  output  16  bit i is set while any queued write targets register i.
REQ-012 SHALL have port busy  output  1  the write queue is non-empty.

Function
- REQ-013 SHALL accept a write on a rising edge where wr_valid=1 and wr_ready=1; nothing is accepted otherwise.
- REQ-014 SHALL buffer accepted writes in a 2-entry in-order queue holding {select, data}; occupancy is 0, 1 or 2.
- REQ-015 SHALL drive wr_ready=1 when occupancy is below 2; wr_ready is a registered value with no combinational path from wr_valid.
- REQ-016 SHALL drain the head entry on any edge where occupancy>0 and hold=0, writing its data into register[select] at that edge.
- REQ-017 SHALL give a latency of exactly one cycle from acceptance (edge N) to register update (edge N+1) when hold=0; a write is never applied on its own acceptance edge.
- REQ-018 SHALL allow a push and a drain on the same edge, leaving occupancy unchanged.
- REQ-019 SHALL apply queued writes in acceptance order; when two entries target the same register, the later value is final.
- REQ-020 SHALL leave the queue frozen while hold=1; pushes are still accepted while occupancy<2.
- REQ-021 SHALL compute pending_mask and busy combinationally from queue contents; at occupancy 0 they are 0.
- REQ-022 SHALL hold every register value until it is overwritten by a drained entry.

Reset
REQ-023 SHALL, on any edge with reset_n=0, clear all registers to 0, set occupancy to 0, drive wr_ready=1, pending_mask=0 and busy=0, and discard queued writes.
REQ-024 SHALL let reset override simultaneous push and drain; no write is accepted or applied on a reset edge.

Configuration
REQ-025 SHALL support the macro REG_WRITE_BANK_R0_ZERO_EN.
- When it is defined, r0 reads constant 0.
- Writes to index 0 are accepted and drained normally but discarded.
- pending_mask[0] remains 0 at all times.
REQ-026 SHALL, when the macro is undefined, treat r0 as an ordinary register.

Structure
REQ-027 SHALL place DATA_W, NUM_REGS, the queue depth constant (2) and the queue-entry typedef {select[3:0], data[DATA_W-1:0]} in the shared package cpu_pkg.
REQ-028 SHALL implement the queue as one sub-module, write_queue2, which performs push and pop only; reg_write_bank contains the storage and the index decode.

Verification
REQ-029 Single write: after reset, wr_valid=1, wr_select=5, wr_data=16'hBEEF for one cycle with hold=0 -> r5=16'hBEEF one edge after acceptance; pending_mask[5] is 1 for exactly that one cycle.
REQ-030 Queue full: hold=1, then two pushes to 3 (16'h0011) and 4 (16'h0022) -> wr_ready=0 and busy=1. Release hold -> r3 is written first, r4 on the next edge, then wr_ready=1.
REQ-031 Simultaneous push and drain: occupancy 1, push 7=16'h0707 while draining -> occupancy stays 1 and r7 is written on the following edge.
REQ-032 Same target: back-to-back writes 9=16'h1111 then 9=16'h2222 -> final r9=16'h2222 and pending_mask[9] clears only after the second drain.
REQ-033 Reset mid-operation: occupancy 2 and hold=1, assert reset_n=0 for one edge -> all r*=0, busy=0 and wr_ready=1; the discarded writes never appear.
REQ-034 Macro defined: write 0=16'hFFFF -> r0 remains 0 and pending_mask remains 0; with the macro undefined, r0=16'hFFFF.
